// File: rtl/game_seq.sv
// Game-flow sequencer: owns status (idle/run/hit/over), lives, score and high score.
// Optional pause support is compiled in with `define GAME_PAUSE_EN.
module game_seq #(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned LIFE_W        = 2,
    parameter int unsigned SCORE_W       = 16,
    parameter int unsigned BONUS_PTS     = 10,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned OVER_FRAMES   = 180,
    parameter int unsigned CNT_W         = 8
) (
`ifdef GAME_PAUSE_EN
    input  logic               pause_btn_i,
    output logic               paused_o,
`endif
    input  logic               clk_vga,
    input  logic               rst,
    input  logic               v_sync_i,
    input  logic               start_btn_i,
    input  logic               crash_me_enemy_i,
    input  logic               crash_enemy_bullet_i,
    input  logic               crash_me_bonus_i,
    output logic [1:0]         game_status_o,
    output logic               gamestart_o,
    output logic               run_en_o,
    output logic               invuln_o,
    output logic [LIFE_W-1:0]  lives_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] hi_score_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HIT  = 2'b10,
        S_OVER = 2'b11
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [LIFE_W-1:0]    r_lives, w_lives_nxt;
    logic [SCORE_W-1:0]   r_score, w_score_nxt;
    logic [SCORE_W-1:0]   r_hi, w_hi_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_gamestart, w_gamestart_nxt;
    logic                 r_run_en, w_run_en_nxt;
    logic                 r_invuln, w_invuln_nxt;
    logic                 r_vs_prev, r_start_prev;

    logic                 w_tick, w_start_edge, w_paused_cur, w_paused_nxt;
    logic [SCORE_W:0]     w_sum;
    logic [SCORE_W-1:0]   w_score_inc;

    assign w_tick       = v_sync_i & ~r_vs_prev;
    assign w_start_edge = start_btn_i & ~r_start_prev;

`ifdef GAME_PAUSE_EN
    logic r_paused, r_pause_prev, w_pause_edge;

    assign w_pause_edge = pause_btn_i & ~r_pause_prev;
    assign w_paused_cur = r_paused;
    assign paused_o     = r_paused;

    // Pause toggles only while a game is actually in play.
    always_comb begin
        w_paused_nxt = r_paused;
        if (w_pause_edge && (r_state == S_RUN || r_state == S_HIT))
            w_paused_nxt = ~r_paused;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_paused     <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_paused     <= w_paused_nxt;
            r_pause_prev <= pause_btn_i;
        end
    end
`else
    assign w_paused_cur = 1'b0;
    assign w_paused_nxt = 1'b0;
`endif

    // Saturating score increment; bullet and bonus in the same cycle sum.
    assign w_sum = {1'b0, r_score}
                 + (SCORE_W+1)'(crash_enemy_bullet_i)
                 + (crash_me_bonus_i ? (SCORE_W+1)'(BONUS_PTS) : (SCORE_W+1)'(0));
    assign w_score_inc = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_score_nxt     = r_score;
        w_hi_nxt        = r_hi;
        w_cnt_nxt       = r_cnt;
        w_gamestart_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt     = S_RUN;
                    w_lives_nxt     = LIFE_W'(LIVES_INIT);
                    w_score_nxt     = '0;
                    w_gamestart_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (!w_paused_cur) begin
                    w_score_nxt = w_score_inc;
                    if (crash_me_enemy_i) begin
                        if (r_lives == LIFE_W'(1)) begin
                            w_state_nxt = S_OVER;
                            w_lives_nxt = '0;
                            w_cnt_nxt   = CNT_W'(OVER_FRAMES);
                            w_hi_nxt    = (w_score_inc > r_hi) ? w_score_inc : r_hi;
                        end else begin
                            w_state_nxt = S_HIT;
                            w_lives_nxt = r_lives - LIFE_W'(1);
                            w_cnt_nxt   = CNT_W'(INVULN_FRAMES);
                        end
                    end
                end
            end
            S_HIT: begin
                if (!w_paused_cur) begin
                    w_score_nxt = w_score_inc;
                    if (w_tick) begin
                        if (r_cnt == CNT_W'(1))
                            w_state_nxt = S_RUN;
                        else
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            S_OVER: begin
                // A start edge only counts once the counter has already reached zero.
                if (w_start_edge && r_cnt == '0) begin
                    w_state_nxt     = S_RUN;
                    w_lives_nxt     = LIFE_W'(LIVES_INIT);
                    w_score_nxt     = '0;
                    w_gamestart_nxt = 1'b1;
                end else if (w_tick && r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_run_en_nxt = (w_state_nxt == S_RUN || w_state_nxt == S_HIT) && !w_paused_nxt;
        w_invuln_nxt = (w_state_nxt == S_HIT);
    end

    // Start history follows the button during reset so a held button needs a re-press.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lives      <= '0;
            r_score      <= '0;
            r_hi         <= '0;
            r_cnt        <= '0;
            r_gamestart  <= 1'b0;
            r_run_en     <= 1'b0;
            r_invuln     <= 1'b0;
            r_vs_prev    <= 1'b0;
            r_start_prev <= start_btn_i;
        end else begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_hi         <= w_hi_nxt;
            r_cnt        <= w_cnt_nxt;
            r_gamestart  <= w_gamestart_nxt;
            r_run_en     <= w_run_en_nxt;
            r_invuln     <= w_invuln_nxt;
            r_vs_prev    <= v_sync_i;
            r_start_prev <= start_btn_i;
        end
    end

    assign game_status_o = r_state;
    assign gamestart_o   = r_gamestart;
    assign run_en_o      = r_run_en;
    assign invuln_o      = r_invuln;
    assign lives_o       = r_lives;
    assign score_o       = r_score;
    assign hi_score_o    = r_hi;

endmodule

// File: tb/tb_game_seq.sv
// Directed bench for game_seq with a queue of expected output snapshots.
module tb_game_seq;

    logic        clk_vga = 1'b0;
    logic        rst = 1'b1;
    logic        v_sync_i = 1'b0;
    logic        start_btn_i = 1'b0;
    logic        crash_me_enemy_i = 1'b0;
    logic        crash_enemy_bullet_i = 1'b0;
    logic        crash_me_bonus_i = 1'b0;
    logic [1:0]  game_status_o;
    logic        gamestart_o, run_en_o, invuln_o;
    logic [1:0]  lives_o;
    logic [15:0] score_o, hi_score_o;
`ifdef GAME_PAUSE_EN
    logic        pause_btn_i = 1'b0;
    logic        paused_o;
`endif

    game_seq dut (
`ifdef GAME_PAUSE_EN
        .pause_btn_i          (pause_btn_i),
        .paused_o             (paused_o),
`endif
        .clk_vga              (clk_vga),
        .rst                  (rst),
        .v_sync_i             (v_sync_i),
        .start_btn_i          (start_btn_i),
        .crash_me_enemy_i     (crash_me_enemy_i),
        .crash_enemy_bullet_i (crash_enemy_bullet_i),
        .crash_me_bonus_i     (crash_me_bonus_i),
        .game_status_o        (game_status_o),
        .gamestart_o          (gamestart_o),
        .run_en_o             (run_en_o),
        .invuln_o             (invuln_o),
        .lives_o              (lives_o),
        .score_o              (score_o),
        .hi_score_o           (hi_score_o)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  lv;
        logic [15:0] sc;
        logic [15:0] hi;
        logic        run;
        logic        inv;
        logic        gs;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_vga);
            #1;
        end
    endtask

    task automatic cmp(input string t, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
        end
    endtask

    task automatic push(input string t, input logic [1:0] st, input logic [1:0] lv,
                        input logic [15:0] sc, input logic [15:0] hi,
                        input logic run, input logic inv, input logic gs);
        exp_t e;
        e = '{st: st, lv: lv, sc: sc, hi: hi, run: run, inv: inv, gs: gs};
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp({t, ".status"}, 16'(game_status_o), 16'(e.st));
            cmp({t, ".lives"},  16'(lives_o),       16'(e.lv));
            cmp({t, ".score"},  score_o,            e.sc);
            cmp({t, ".hi"},     hi_score_o,         e.hi);
            cmp({t, ".run_en"}, 16'(run_en_o),      16'(e.run));
            cmp({t, ".invuln"}, 16'(invuln_o),      16'(e.inv));
            cmp({t, ".gstart"}, 16'(gamestart_o),   16'(e.gs));
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            v_sync_i = 1'b1; cyc();
            v_sync_i = 1'b0; cyc();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc();
    endtask

    initial begin
        // Reset with start held: no game may begin until the button is re-pressed.
        start_btn_i = 1'b1;
        do_reset();
        cyc(2);
        push("held_start", 2'b00, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        start_btn_i = 1'b0; cyc();
`ifdef GAME_PAUSE_EN
        cmp("reset.paused", 16'(paused_o), 16'd0);
`endif
        // Crash pulses in IDLE ignored.
        crash_enemy_bullet_i = 1'b1; crash_me_enemy_i = 1'b1; cyc();
        crash_enemy_bullet_i = 1'b0; crash_me_enemy_i = 1'b0; cyc();
        push("idle_crash", 2'b00, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        check_out();

        // Start the game: gamestart one cycle only.
        start_btn_i = 1'b1; cyc();
        push("start", 2'b01, 2'd3, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        check_out();
        start_btn_i = 1'b0; cyc();
        push("start+1", 2'b01, 2'd3, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        check_out();

        // Scoring: 3 bullets, 1 bonus, bullet+bonus together -> 24.
        for (int i = 0; i < 3; i++) begin
            crash_enemy_bullet_i = 1'b1; cyc();
            crash_enemy_bullet_i = 1'b0; cyc();
        end
        push("bullets3", 2'b01, 2'd3, 16'd3, 16'd0, 1'b1, 1'b0, 1'b0);
        check_out();
        crash_me_bonus_i = 1'b1; cyc(); crash_me_bonus_i = 1'b0; cyc();
        crash_me_bonus_i = 1'b1; crash_enemy_bullet_i = 1'b1; cyc();
        crash_me_bonus_i = 1'b0; crash_enemy_bullet_i = 1'b0;
        push("score24", 2'b01, 2'd3, 16'd24, 16'd0, 1'b1, 1'b0, 1'b0);
        check_out();

        // First life lost; a second crash during HIT is ignored, scoring still counts.
        crash_me_enemy_i = 1'b1; cyc(); crash_me_enemy_i = 1'b0;
        push("hit1", 2'b10, 2'd2, 16'd24, 16'd0, 1'b1, 1'b1, 1'b0);
        check_out();
        cyc();
        crash_me_enemy_i = 1'b1; crash_enemy_bullet_i = 1'b1; cyc();
        crash_me_enemy_i = 1'b0; crash_enemy_bullet_i = 1'b0;
        push("hit_crash", 2'b10, 2'd2, 16'd25, 16'd0, 1'b1, 1'b1, 1'b0);
        check_out();
        tick(119);
        push("hit119", 2'b10, 2'd2, 16'd25, 16'd0, 1'b1, 1'b1, 1'b0);
        check_out();
        tick(1);
        push("hit120", 2'b01, 2'd2, 16'd25, 16'd0, 1'b1, 1'b0, 1'b0);
        check_out();

        // Second life.
        crash_me_enemy_i = 1'b1; cyc(); crash_me_enemy_i = 1'b0;
        push("hit2", 2'b10, 2'd1, 16'd25, 16'd0, 1'b1, 1'b1, 1'b0);
        check_out();
        tick(120);
        push("run2", 2'b01, 2'd1, 16'd25, 16'd0, 1'b1, 1'b0, 1'b0);
        check_out();

        // Last life with a simultaneous bullet: hi score includes it.
        crash_me_enemy_i = 1'b1; crash_enemy_bullet_i = 1'b1; cyc();
        crash_me_enemy_i = 1'b0; crash_enemy_bullet_i = 1'b0;
        push("over", 2'b11, 2'd0, 16'd26, 16'd26, 1'b0, 1'b0, 1'b0);
        check_out();
        crash_enemy_bullet_i = 1'b1; crash_me_bonus_i = 1'b1; cyc();
        crash_enemy_bullet_i = 1'b0; crash_me_bonus_i = 1'b0; cyc();
        push("over_frozen", 2'b11, 2'd0, 16'd26, 16'd26, 1'b0, 1'b0, 1'b0);
        check_out();

        // Start at frame 100 dropped; tick+start with cnt==1 dropped; then restart.
        tick(100);
        start_btn_i = 1'b1; cyc(); start_btn_i = 1'b0; cyc();
        push("over_early", 2'b11, 2'd0, 16'd26, 16'd26, 1'b0, 1'b0, 1'b0);
        check_out();
        tick(79);
        v_sync_i = 1'b1; start_btn_i = 1'b1; cyc();
        v_sync_i = 1'b0; start_btn_i = 1'b0;
        push("over_tick_start", 2'b11, 2'd0, 16'd26, 16'd26, 1'b0, 1'b0, 1'b0);
        check_out();
        cyc();
        start_btn_i = 1'b1; cyc(); start_btn_i = 1'b0;
        push("restart", 2'b01, 2'd3, 16'd0, 16'd26, 1'b1, 1'b0, 1'b1);
        check_out();
        cyc();

        // Saturation: 6552 bonus + 8 bullets = 0xFFF8, then bonus/bullet clamp at 0xFFFF.
        crash_me_bonus_i = 1'b1; cyc(6552); crash_me_bonus_i = 1'b0;
        crash_enemy_bullet_i = 1'b1; cyc(8); crash_enemy_bullet_i = 1'b0;
        push("sat_fff8", 2'b01, 2'd3, 16'hFFF8, 16'd26, 1'b1, 1'b0, 1'b0);
        check_out();
        crash_me_bonus_i = 1'b1; cyc(); crash_me_bonus_i = 1'b0;
        push("sat_bonus", 2'b01, 2'd3, 16'hFFFF, 16'd26, 1'b1, 1'b0, 1'b0);
        check_out();
        crash_enemy_bullet_i = 1'b1; cyc(); crash_enemy_bullet_i = 1'b0;
        push("sat_bullet", 2'b01, 2'd3, 16'hFFFF, 16'd26, 1'b1, 1'b0, 1'b0);
        check_out();
        crash_enemy_bullet_i = 1'b1; crash_me_bonus_i = 1'b1; cyc();
        crash_enemy_bullet_i = 1'b0; crash_me_bonus_i = 1'b0;
        push("sat_both", 2'b01, 2'd3, 16'hFFFF, 16'd26, 1'b1, 1'b0, 1'b0);
        check_out();

        // Mid-game reset clears everything including hi score.
        do_reset();
        push("midreset", 2'b00, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        check_out();

`ifdef GAME_PAUSE_EN
        // Pause in HIT with cnt=50: frames and crashes ignored until unpaused.
        start_btn_i = 1'b1; cyc(); start_btn_i = 1'b0; cyc();
        crash_me_enemy_i = 1'b1; cyc(); crash_me_enemy_i = 1'b0;
        tick(70);
        pause_btn_i = 1'b1; cyc(); pause_btn_i = 1'b0;
        push("paused", 2'b10, 2'd2, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        check_out();
        cmp("paused.flag", 16'(paused_o), 16'd1);
        tick(200);
        crash_enemy_bullet_i = 1'b1; crash_me_bonus_i = 1'b1; cyc();
        crash_enemy_bullet_i = 1'b0; crash_me_bonus_i = 1'b0; cyc();
        push("paused200", 2'b10, 2'd2, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        check_out();
        pause_btn_i = 1'b1; cyc(); pause_btn_i = 1'b0; cyc();
        cmp("unpaused.flag", 16'(paused_o), 16'd0);
        tick(49);
        push("resume49", 2'b10, 2'd2, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
        check_out();
        tick(1);
        push("resume50", 2'b01, 2'd2, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        check_out();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
